// File: rtl/norm_seq_ctrl_pkg.sv
// Shared constants, state encoding and result-flag bundle for the FP normalization sequencer.
// Widths are fixed by the CalcMSBPos leading-one detector (31-bit input, 5-bit position).
package norm_seq_ctrl_pkg;

    localparam int NORM_IN_W    = 31;
    localparam int NORM_FRAC_W  = 23;
    localparam int NORM_EXP_W   = 8;
    localparam int NORM_EXP_MAX = (1 << NORM_EXP_W) - 1;
    localparam int NORM_POS_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DETECT = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_DONE   = 2'd3
    } norm_state_t;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic unf;
    } norm_flags_t;

    // Detector reports position+1 so that 0 can mean "no bit set".
    function automatic logic [NORM_POS_W-1:0] lead_index(input logic [NORM_POS_W-1:0] pos);
        return pos - NORM_POS_W'(1);
    endfunction

endpackage

// File: rtl/CalcMSBPos.sv
// Leading-one detector: oPos = index of the highest set bit plus one, oAct = any bit set.
// oPos is 0 when iData is 0.
module CalcMSBPos
    import norm_seq_ctrl_pkg::*;
(
    input  logic [NORM_IN_W-1:0]  iData,
    output logic [NORM_POS_W-1:0] oPos,
    output logic                  oAct
);

    always_comb begin
        oPos = '0;
        oAct = |iData;
        for (int i = 0; i < NORM_IN_W; i++) begin
            if (iData[i]) begin
                oPos = NORM_POS_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/norm_shift_unit.sv
// Combinational barrel shift, exponent adjust and zero/overflow/underflow classification.
// Underflow behaviour depends on NORM_FTZ_EN (defined: flush to zero; undefined: denormal fraction).
module norm_shift_unit
    import norm_seq_ctrl_pkg::*;
#(
    parameter int EXP_W  = NORM_EXP_W,
    parameter int FRAC_W = NORM_FRAC_W,
    parameter int IN_W   = NORM_IN_W,
    parameter int POS_W  = NORM_POS_W
) (
    input  logic [EXP_W-1:0]  iExp,
    input  logic [IN_W-1:0]   iMant,
    input  logic [POS_W-1:0]  iPos,
    input  logic              iAct,
    output logic [EXP_W-1:0]  oExp,
    output logic [FRAC_W-1:0] oMant,
    output norm_flags_t       oFlags
);

    localparam int EW      = EXP_W + 2;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    logic [POS_W-1:0]     k;
    logic signed [EW-1:0] e_s;
    logic [IN_W-1:0]      norm_sh;
    logic [IN_W-1:0]      denorm_sh;

    always_comb begin
        k   = lead_index(iPos);
        e_s = $signed({2'b00, iExp}) + $signed(EW'(k)) - $signed(EW'(FRAC_W));

        // Bring the leading one onto the hidden-bit position; right shifts truncate.
        if (k > POS_W'(FRAC_W)) begin
            norm_sh = iMant >> (k - POS_W'(FRAC_W));
        end else begin
            norm_sh = iMant << (POS_W'(FRAC_W) - k);
        end

        if (iExp != '0) begin
            denorm_sh = iMant << (iExp - EXP_W'(1));
        end else begin
            denorm_sh = iMant >> 1;
        end

        oExp   = e_s[EXP_W-1:0];
        oMant  = norm_sh[FRAC_W-1:0];
        oFlags = '0;

        if (!iAct) begin
            oExp        = '0;
            oMant       = '0;
            oFlags.zero = 1'b1;
        end else if (e_s >= $signed(EW'(EXP_MAX))) begin
            oExp       = '1;
            oMant      = '0;
            oFlags.ovf = 1'b1;
        end else if (e_s <= $signed(EW'(0))) begin
            oExp       = '0;
            oFlags.unf = 1'b1;
`ifdef NORM_FTZ_EN
            oMant       = '0;
            oFlags.zero = 1'b1;
`else
            oMant       = denorm_sh[FRAC_W-1:0];
            oFlags.zero = (denorm_sh[FRAC_W-1:0] == '0);
`endif
        end
    end

endmodule

// File: rtl/norm_seq_ctrl.sv
// FP normalization sequencer: IDLE -> DETECT -> SHIFT -> DONE, one operand in flight at a time.
// Build option NORM_FTZ_EN (see norm_shift_unit) selects flush-to-zero on exponent underflow.
module norm_seq_ctrl
    import norm_seq_ctrl_pkg::*;
#(
    parameter int EXP_W  = NORM_EXP_W,
    parameter int FRAC_W = NORM_FRAC_W,
    parameter int IN_W   = NORM_IN_W
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iAbort,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iSign,
    input  logic [EXP_W-1:0]  iExp,
    input  logic [IN_W-1:0]   iMant,
    output logic              oValid,
    input  logic              iReady,
    output logic              oSign,
    output logic [EXP_W-1:0]  oExp,
    output logic [FRAC_W-1:0] oMant,
    output logic              oZero,
    output logic              oOvf,
    output logic              oUnf
);

    localparam int POS_W = NORM_POS_W;

    if (IN_W != NORM_IN_W) begin : g_in_w_check
        $error("norm_seq_ctrl: IN_W is fixed at 31 by CalcMSBPos");
    end

    norm_state_t       state_q, state_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              op_sign_q, op_sign_d;
    logic [EXP_W-1:0]  op_exp_q, op_exp_d;
    logic [IN_W-1:0]   op_mant_q, op_mant_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              act_q, act_d;
    logic              sign_q, sign_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [FRAC_W-1:0] mant_q, mant_d;
    norm_flags_t       flags_q, flags_d;

    logic [POS_W-1:0]  det_pos;
    logic              det_act;
    logic [EXP_W-1:0]  sh_exp;
    logic [FRAC_W-1:0] sh_mant;
    norm_flags_t       sh_flags;

    CalcMSBPos u_msb (
        .iData (op_mant_q),
        .oPos  (det_pos),
        .oAct  (det_act)
    );

    norm_shift_unit #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W),
        .IN_W   (IN_W),
        .POS_W  (POS_W)
    ) u_shift (
        .iExp   (op_exp_q),
        .iMant  (op_mant_q),
        .iPos   (pos_q),
        .iAct   (act_q),
        .oExp   (sh_exp),
        .oMant  (sh_mant),
        .oFlags (sh_flags)
    );

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        valid_d   = valid_q;
        op_sign_d = op_sign_q;
        op_exp_d  = op_exp_q;
        op_mant_d = op_mant_q;
        pos_d     = pos_q;
        act_d     = act_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        flags_d   = flags_q;

        // Abort beats everything, but the last result stays on the data outputs.
        if (iAbort) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (iValid && ready_q) begin
                        op_sign_d = iSign;
                        op_exp_d  = iExp;
                        op_mant_d = iMant;
                        ready_d   = 1'b0;
                        state_d   = ST_DETECT;
                    end
                end
                ST_DETECT: begin
                    pos_d   = det_pos;
                    act_d   = det_act;
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    sign_d  = op_sign_q;
                    exp_d   = sh_exp;
                    mant_d  = sh_mant;
                    flags_d = sh_flags;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (iReady) begin
                        valid_d = 1'b0;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            op_sign_q <= 1'b0;
            op_exp_q  <= '0;
            op_mant_q <= '0;
            pos_q     <= '0;
            act_q     <= 1'b0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            op_sign_q <= op_sign_d;
            op_exp_q  <= op_exp_d;
            op_mant_q <= op_mant_d;
            pos_q     <= pos_d;
            act_q     <= act_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            mant_q    <= mant_d;
            flags_q   <= flags_d;
        end
    end

    assign oReady = ready_q;
    assign oValid = valid_q;
    assign oSign  = sign_q;
    assign oExp   = exp_q;
    assign oMant  = mant_q;
    assign oZero  = flags_q.zero;
    assign oOvf   = flags_q.ovf;
    assign oUnf   = flags_q.unf;

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// Directed, table-driven bench for norm_seq_ctrl plus hand-written backpressure/abort/reset sequences.
// Expected values follow NORM_FTZ_EN when the bench is built with it.
module tb_norm_seq_ctrl;

`ifdef NORM_FTZ_EN
    localparam bit FTZ = 1'b1;
`else
    localparam bit FTZ = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iAbort;
    logic        iValid;
    logic        oReady;
    logic        iSign;
    logic [7:0]  iExp;
    logic [30:0] iMant;
    logic        oValid;
    logic        iReady;
    logic        oSign;
    logic [7:0]  oExp;
    logic [22:0] oMant;
    logic        oZero;
    logic        oOvf;
    logic        oUnf;

    int checks   = 0;
    int failures = 0;

    norm_seq_ctrl dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iAbort (iAbort),
        .iValid (iValid),
        .oReady (oReady),
        .iSign  (iSign),
        .iExp   (iExp),
        .iMant  (iMant),
        .oValid (oValid),
        .iReady (iReady),
        .oSign  (oSign),
        .oExp   (oExp),
        .oMant  (oMant),
        .oZero  (oZero),
        .oOvf   (oOvf),
        .oUnf   (oUnf)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [30:0] m;
        logic [7:0]  xe;
        logic [22:0] xm;
        logic        xz;
        logic        xo;
        logic        xu;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && !oReady; i++) step();
        chk({tag, "_ready_timeout"}, 32'(oReady), 32'd1);
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, "_sign"}, 32'(oSign), 32'(v.s));
        chk({tag, "_exp"},  32'(oExp),  32'(v.xe));
        chk({tag, "_mant"}, 32'(oMant), 32'(v.xm));
        chk({tag, "_zero"}, 32'(oZero), 32'(v.xz));
        chk({tag, "_ovf"},  32'(oOvf),  32'(v.xo));
        chk({tag, "_unf"},  32'(oUnf),  32'(v.xu));
    endtask

    task automatic handshake(input logic s, input logic [7:0] e, input logic [30:0] m);
        iSign  = s;
        iExp   = e;
        iMant  = m;
        iValid = 1'b1;
        step();
        iValid = 1'b0;
        iSign  = ~s;
        iExp   = ~e;
        iMant  = ~m;
    endtask

    task automatic run_op(input string tag, input vec_t v);
        wait_ready(tag);
        iReady = 1'b1;
        handshake(v.s, v.e, v.m);
        chk({tag, "_lat_e0"}, 32'(oValid), 32'd0);
        chk({tag, "_busy"},   32'(oReady), 32'd0);
        step();
        chk({tag, "_lat_e1"}, 32'(oValid), 32'd0);
        step();
        chk({tag, "_lat_e2"}, 32'(oValid), 32'd1);
        check_result(tag, v);
        step();
        chk({tag, "_ready_back"}, 32'(oReady), 32'd1);
        chk({tag, "_valid_drop"}, 32'(oValid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  held_exp;
        logic [22:0] held_mant;
        vec_t        zv;

        vecs[0]  = '{1'b0, 8'd127, 31'h0080_0000, 8'd127, 23'h0,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'd100, 31'h4000_0001, 8'd107, 23'h0,        1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'd127, 31'h0000_0001, 8'd104, 23'h0,        1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'd250, 31'h4000_0000, 8'd255, 23'h0,        1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'd10,  31'h0000_0001, 8'd0,   FTZ ? 23'h0 : 23'h200,    FTZ, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 8'd127, 31'h0123_4567, 8'd128, 23'h11_A2B3,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'd5,   31'h0000_00FF, 8'd0,   FTZ ? 23'h0 : 23'hFF0,    FTZ, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 8'd0,   31'h0000_0006, 8'd0,   FTZ ? 23'h0 : 23'h3,      FTZ, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 8'd200, 31'h0000_0000, 8'd0,   23'h0,        1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'd255, 31'h0080_0000, 8'd255, 23'h0,        1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'd254, 31'h00C0_0000, 8'd254, 23'h40_0000,  1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'd0,   31'h0080_0000, 8'd0,   FTZ ? 23'h0 : 23'h40_0000, FTZ, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 8'd1,   31'h0080_0000, 8'd1,   23'h0,        1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'd0,   31'h0000_0001, 8'd0,   23'h0,        1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 8'd50,  31'h7FFF_FFFF, 8'd57,  23'h7F_FFFF,  1'b0, 1'b0, 1'b0};

        iRst_n = 1'b0;
        iAbort = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        iSign  = 1'b0;
        iExp   = '0;
        iMant  = '0;

        #12;
        chk("rst_ready", 32'(oReady), 32'd1);
        chk("rst_valid", 32'(oValid), 32'd0);
        chk("rst_data",  {oSign, oZero, oOvf, oUnf, oExp, 5'd0, oMant[12:0]}, 32'd0);
        chk("rst_mant",  32'(oMant), 32'd0);
        #6;
        iRst_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Zero operand with downstream stalled for five cycles.
        zv = '{1'b1, 8'd77, 31'h0, 8'd0, 23'h0, 1'b1, 1'b0, 1'b0};
        wait_ready("stall");
        iReady = 1'b0;
        handshake(1'b1, 8'd77, 31'h0);
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_valid", c), 32'(oValid), 32'd1);
            chk($sformatf("stall%0d_ready", c), 32'(oReady), 32'd0);
            check_result($sformatf("stall%0d", c), zv);
            step();
        end
        iReady = 1'b1;
        step();
        chk("stall_ready_back", 32'(oReady), 32'd1);
        chk("stall_valid_drop", 32'(oValid), 32'd0);

        // Abort while in DETECT: operand dropped, previous result data kept.
        held_exp  = oExp;
        held_mant = oMant;
        handshake(1'b0, 8'd127, 31'h0080_0000);
        iAbort = 1'b1;
        step();
        iAbort = 1'b0;
        chk("abort_ready", 32'(oReady), 32'd1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("abort%0d_valid", c), 32'(oValid), 32'd0);
            step();
        end
        chk("abort_exp_held",  32'(oExp),  32'(held_exp));
        chk("abort_mant_held", 32'(oMant), 32'(held_mant));
        run_op("post_abort", vecs[5]);

        // Asynchronous reset while in SHIFT.
        handshake(1'b0, 8'd250, 31'h4000_0000);
        step();
        iRst_n = 1'b0;
        #2;
        chk("mid_rst_ready", 32'(oReady), 32'd1);
        chk("mid_rst_valid", 32'(oValid), 32'd0);
        chk("mid_rst_exp",   32'(oExp),   32'd0);
        iRst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("mid_rst%0d_valid", c), 32'(oValid), 32'd0);
        end
        run_op("post_rst", vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
